// File: rtl/pattern_capture_pkg.sv
// Shared types and helpers for the pattern generator / capture pair.
// Holds the GPIO-width encoding, capture FSM states and timestep decoding.
package pattern_pkg;

    typedef enum logic [1:0] {
        GPIO_1 = 2'b00,
        GPIO_2 = 2'b01,
        GPIO_4 = 2'b10,
        GPIO_8 = 2'b11
    } num_gpio_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } cap_state_e;

    // Terminal count of the timestep counter: period 2^(sel+1), saturating at 2^24.
    function automatic logic [23:0] ts_final_count(input logic [4:0] sel);
        logic [24:0] period;
        if (sel >= 5'd23) begin
            return 24'hFF_FFFF;
        end
        period = 25'd1 << (sel + 5'd1);
        return period[23:0] - 24'd1;
    endfunction

    // Index of the sample that completes a byte (8/W - 1).
    function automatic logic [2:0] last_sample_idx(input num_gpio_e w);
        case (w)
            GPIO_1:  return 3'd7;
            GPIO_2:  return 3'd3;
            GPIO_4:  return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) begin
            r[7-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pattern_capture_if.sv
// SRAM write port shared by the capture engine (master) and SRAM controller (slave).
interface pattern_capture_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              sram_wr_req;
    logic              sram_wr_ack;
    logic [ADDR_W-1:0] sram_addr_cap;
    logic [7:0]        sram_wdata_cap;

    modport master (
        output sram_wr_req,
        output sram_addr_cap,
        output sram_wdata_cap,
        input  sram_wr_ack
    );

    modport slave (
        input  sram_wr_req,
        input  sram_addr_cap,
        input  sram_wdata_cap,
        output sram_wr_ack
    );
endinterface

// File: rtl/pattern_capture_timestep_tick_gen.sv
// Free-running timestep counter with a tick on count zero; shared with the generator.
module timestep_tick_gen #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] final_count,
    output logic             tick
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == final_count) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && !clear && (cnt == '0);

endmodule

// File: rtl/pattern_capture.sv
// Logic-analyzer capture engine: samples W GPIOs per timestep, packs MSB-first, writes SRAM.
// Optional start trigger compiled in with `define PATTERN_CAPTURE_TRIGGER_EN.
module pattern_capture
    import pattern_pkg::*;
#(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned TS_CNT_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_cap,
    input  logic [23:0]       end_address_cap,
    input  logic [1:0]        num_gpio_sel_cap,
    input  logic [4:0]        timestep_sel_cap,
    input  logic [2:0]        trigger_sel_cap,
    input  logic              trigger_pol_cap,
    input  logic [7:0]        gpio_cap_in,
    output logic              capture_active,
    output logic              capture_done,
    output logic              capture_overrun,
    pattern_capture_if.master sram
);
    cap_state_e        state_q, state_d;
    logic              enable_d;
    logic              enable_rise;
    logic              tick;
    logic              byte_done;
    logic              last_addr;
    logic              ack;
    logic              trig_edge;
    logic [3:0]        w;
    logic [7:0]        shreg_q, shreg_next;
    logic [2:0]        k_q;
    logic [ADDR_W-1:0] cur_addr_q, addr_q;
    logic [7:0]        wdata_q;
    logic              req_q, done_q, overrun_q;

    assign enable_rise = enable_cap && !enable_d;
    assign w           = 4'd1 << num_gpio_sel_cap;
    assign byte_done   = tick && (k_q == last_sample_idx(num_gpio_e'(num_gpio_sel_cap)));
    assign last_addr   = (cur_addr_q == end_address_cap[ADDR_W-1:0]);
    assign ack         = sram.sram_wr_ack && req_q;

    // gpio[0] lands in the most significant bit of each W-bit group.
    assign shreg_next = (shreg_q << w) | (bit_reverse8(gpio_cap_in) >> (4'd8 - w));

`ifdef PATTERN_CAPTURE_TRIGGER_EN
    logic trig_bit, trig_d;
    logic unused_end_bits;

    assign trig_bit  = gpio_cap_in[trigger_sel_cap];
    assign trig_edge = trigger_pol_cap ? (trig_bit && !trig_d) : (!trig_bit && trig_d);
    assign unused_end_bits = ^(end_address_cap >> ADDR_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trig_bit;
        end
    end
`else
    logic unused_inputs;

    assign trig_edge     = 1'b1;
    assign unused_inputs = ^{trigger_sel_cap, trigger_pol_cap, end_address_cap >> ADDR_W};
`endif

    timestep_tick_gen #(
        .CNT_W (TS_CNT_W)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (!enable_cap || (state_q != CAPTURE)),
        .en          (state_q == CAPTURE),
        .final_count (TS_CNT_W'(ts_final_count(timestep_sel_cap))),
        .tick        (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_rise) state_d = ARM;
            ARM:     if (trig_edge) state_d = CAPTURE;
            CAPTURE: if (byte_done && last_addr) state_d = FLUSH;
            FLUSH:   if (ack) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (!enable_cap) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        capture_active = 1'b0;
        if (state_q == ARM || state_q == CAPTURE || state_q == FLUSH) begin
            capture_active = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            enable_d   <= 1'b0;
            shreg_q    <= '0;
            k_q        <= '0;
            cur_addr_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_d <= enable_cap;
            if (!enable_cap) begin
                shreg_q    <= '0;
                k_q        <= '0;
                cur_addr_q <= '0;
                addr_q     <= '0;
                wdata_q    <= '0;
                req_q      <= 1'b0;
                done_q     <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                if (tick) begin
                    shreg_q <= shreg_next;
                    k_q     <= byte_done ? 3'd0 : k_q + 3'd1;
                end
                // An ack landing with a completing byte frees the port for the new byte.
                if (byte_done) begin
                    if (req_q && !sram.sram_wr_ack) begin
                        overrun_q <= 1'b1;
                    end else begin
                        req_q   <= 1'b1;
                        addr_q  <= cur_addr_q;
                        wdata_q <= shreg_next;
                    end
                    cur_addr_q <= cur_addr_q + ADDR_W'(1);
                end else if (ack) begin
                    req_q <= 1'b0;
                end
                if (state_q == FLUSH && ack) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign capture_done        = done_q;
    assign capture_overrun     = overrun_q;
    assign sram.sram_wr_req    = req_q;
    assign sram.sram_addr_cap  = addr_q;
    assign sram.sram_wdata_cap = wdata_q;

endmodule

// File: doc/pattern_capture.md
Name: pattern_capture

Overview:
- Logic-analyzer capture engine; the receive-side counterpart of the pattern generator.
- Samples 1/2/4/8 GPIO inputs once per programmable timestep and packs the samples MSB-first into bytes.
- Writes the bytes to the shared SRAM through a req/ack write port, from address 0 to a programmed end address.
- Byte packing is the exact inverse of the generator's unpacking, so a captured image replays bit-identically.

Parameters:
- ADDR_W, 19, SRAM byte-address width.
- TS_CNT_W, 24, timestep counter width; must be at least 24.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- enable_cap  input  1  level; rising edge starts capture; low aborts and clears.
- end_address_cap  input  24  last byte address; only bits [ADDR_W-1:0] are used.
- num_gpio_sel_cap  input  2  00=1, 01=2, 10=4, 11=8 GPIOs (W).
- timestep_sel_cap  input  5  sample period P = 2^(sel+1) clocks; sel>=23 gives P = 2^24.
- trigger_sel_cap  input  3  GPIO index used as trigger; used only with the optional feature.
- trigger_pol_cap  input  1  1=rising, 0=falling trigger edge; used only with the optional feature.
- gpio_cap_in  input  8  already-synchronised GPIO inputs.
- capture_active  output  1  high while in ARM, CAPTURE or FLUSH.
- capture_done  output  1  sticky; set on entry to DONE.
- capture_overrun  output  1  sticky; a byte was dropped.
- sram_wr_req  output  1  write request.
- sram_wr_ack  input  1  one-cycle accept strobe from the SRAM controller.
- sram_addr_cap  output  ADDR_W  write address.
- sram_wdata_cap  output  8  write data.

Behaviour:
- Reset: state=IDLE; every output 0; counters, shift register and address 0.
- enable_cap low in any state: next cycle state=IDLE, all outputs and internals cleared, pending sram_wr_req dropped.
- FSM IDLE -> ARM: on enable rising edge (enable_cap=1 and its 1-cycle delayed copy=0).
- FSM ARM -> CAPTURE: immediately (next cycle) unless the optional feature is compiled in.
- FSM CAPTURE -> FLUSH: when the byte for end_address is completed.
- FSM FLUSH -> DONE: on sram_wr_ack.
- FSM DONE: holds until enable_cap goes low; no restart without a new rising edge.
- Timestep: counter is 0 on CAPTURE entry, counts 0..P-1 and wraps; sample tick when counter==0 in CAPTURE. First sample is taken in the first CAPTURE cycle.
- Packing: sample k within a byte (k=0..8/W-1) maps gpio_cap_in[i] (i<W) to byte bit 7-k*W-i. Unused GPIO inputs are ignored.
- Byte complete on sample k=8/W-1. Next cycle: sram_wdata_cap=byte, sram_addr_cap=current address, sram_wr_req=1; current address then increments.
- Req/ack: req, addr and data are held stable until the cycle ack=1; req deasserts the cycle after ack. Ack while req=0 is ignored.
- Overrun: a byte completes while req=1 and ack=0 -> byte dropped, capture_overrun set, address still increments to keep time alignment.
- end_address_cap=0: exactly one byte is written.
- Settings are sampled live; changing them mid-capture is undefined. Benches must not do it.
- Latency: sample tick to req assertion = 1 clock after the completing sample.

Optional Feature:
- Macro PATTERN_CAPTURE_TRIGGER_EN.
- Defined: ARM waits for the selected edge on gpio_cap_in[trigger_sel_cap], compared against a 1-cycle delayed copy; CAPTURE is entered the cycle after the edge is detected.
- Not defined: ARM lasts one cycle; trigger ports are ignored.

Decomposition:
- Package pattern_pkg holds:
  - num_gpio_sel encoding enum;
  - capture FSM state enum (IDLE, ARM, CAPTURE, FLUSH, DONE);
  - function timestep_sel -> final count (2^(sel+1)-1, saturating at 2^24-1), shared with the generator.
- Natural sub-module: timestep_tick_gen (counter plus tick), reusable by the generator.

Test Plan:
- W=1, sel=0, gpio[0] sequence 1,0,1,1,0,0,1,0, end=0, ack 1 cycle after req -> one write addr 0 data 0xB2; capture_done=1; overrun=0.
- W=4, sel=1, samples 4'b0011 then 4'b1000, end=1 -> addr 0 data 0xC1; samples spaced 4 clocks apart.
- W=8, sel=0, gpio increments 0x00..0x03, end=3 -> data 0x00,0x80,0x40,0xC0 at addr 0..3.
- W=8, sel=0, ack withheld 6 cycles -> capture_overrun=1; dropped addresses not written; done still asserted after final ack.
- enable_cap dropped mid-CAPTURE with req pending -> next cycle all outputs 0; re-enable restarts at addr 0.
- With macro: trigger_sel=5, pol=1, gpio[5] rises after 20 cycles -> no req before the edge; first sample on the cycle after detection.
